led_pwm_ctrl: RTL
=================

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 The block SHALL have parameter NCH, default 3, meaning number of LED channels (1..16).
REQ-002 The block SHALL have parameter DW, default 8, meaning PWM counter and duty width.
REQ-003 The block SHALL have parameter PSW, default 16, meaning prescaler width.
REQ-004 The block SHALL have parameter BLW, default 6, meaning blink frame counter width.
REQ-005 The block SHALL have port mclk  in  1  the single clock, rising edge.
REQ-006 The block SHALL have port mrst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port cfg_we  in  1  config write strobe, one write per cycle.
REQ-008 The block SHALL have port cfg_ch  in  4  target channel index.
REQ-009 The block SHALL have port cfg_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
REQ-010 The block SHALL have port cfg_duty  in  DW  duty, or breathe peak.
REQ-011 The block SHALL have port prescale  in  PSW  tick divider, sampled live every cycle.
REQ-012 The block SHALL have port led  out  NCH  registered LED drive, one bit per channel.
REQ-013 The block SHALL have port frame_tick  out  1  registered one-cycle pulse at PWM frame wrap.

Function
REQ-014 Prescaler psc: on tick (psc >= prescale), psc<=0; otherwise psc<=psc+1; prescale=0 gives a tick every cycle.
REQ-015 Lowering prescale below the current psc SHALL produce a tick on the next cycle, with no lockup.
REQ-016 PWM counter pwm (DW bits) SHALL increment on tick only and wrap from 2^DW-1 to 0.
REQ-017 Frame event: tick AND pwm==2^DW-1; frame_tick SHALL be high exactly the cycle after the frame event.
REQ-018 Per channel, a shadow register {mode,duty} SHALL load on cfg_we when cfg_ch==ch; writes with cfg_ch>=NCH SHALL be ignored.
REQ-019 On a frame event, every active register SHALL load its shadow value.
REQ-020 A cfg_we in the same cycle as a frame event SHALL update the shadow only; the active register SHALL get the pre-write shadow value, and the new value SHALL commit at the next frame event.
REQ-021 Blink counter blc (BLW bits) SHALL increment on each frame event and wrap; blink phase = blc MSB.
REQ-022 Breathe state per channel: level (DW bits) plus dir; a commit that changes mode into BREATHE SHALL set level=0, dir=up.
REQ-023 On a frame event in BREATHE, with dir up: level<duty -> level+1; else dir<=down and level<=level-1 if level>0.
REQ-024 On a frame event in BREATHE, with dir down: level>0 -> level-1; else dir<=up and level<=1 if duty>0 (duty=0 keeps level 0).
REQ-025 Effective duty eff: OFF=0; ON=duty; BLINK=duty when phase=1, else 0; BREATHE=level.
REQ-026 led[ch] SHALL register (pwm < eff[ch]) each cycle, one-cycle latency from pwm; eff=2^DW-1 gives high 2^DW-1 of 2^DW slots.
REQ-027 Channels SHALL be fully independent; the prescaler, pwm and blc SHALL be shared.
REQ-028 Active values SHALL change only at frame events, so duty/mode updates never truncate a PWM period.

Reset
REQ-029 On mrst_n low, all state SHALL clear immediately, without waiting for a clock edge: psc, pwm, blc=0; shadow/active mode=OFF, duty=0; level=0, dir=up; led=0; frame_tick=0.
REQ-030 Reset asserted mid-frame SHALL discard all pending shadow writes; after release, counting SHALL restart from psc=0, pwm=0.

Verification (NCH=3, DW=4, BLW=2, prescale=0)
REQ-031 Write ch0 ON duty=4 then wait for commit -> led[0] high 4 of every 16 cycles, frame_tick every 16 cycles, led[1:2]=0.
REQ-032 Write ch1 ON duty=8 at mid-frame -> led[1] unchanged until the frame event; the first full frame after it has 8 high cycles.
REQ-033 ch2 BLINK duty=15 -> 2 frames with 15 high cycles each, then 2 frames all-low, repeating.
REQ-034 ch0 BREATHE duty=3 -> per-frame high counts 0,1,2,3,2,1,0,1,...; cfg_ch=5 writes cause no change.
REQ-035 cfg_we coincident with a frame event -> the old shadow value commits; the new value appears one frame later.
REQ-036 Assert mrst_n low mid-frame with led high -> led=0 and frame_tick=0 asynchronously; after release, all channels stay OFF.

Source files
------------

// File: rtl/led_pwm_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// led_pwm_ctrl
//   Multi-channel LED PWM controller. A shared prescaler produces count ticks.
//   A shared DW-bit PWM counter advances on each tick. A shared blink frame
//   counter advances once per PWM frame. Each channel has a shadow {mode,duty}
//   register written over the config port. The shadow is copied into the active
//   register only at a frame wrap, so a PWM period is never cut short.
//   Modes: OFF, ON (fixed duty), BLINK (duty on alternate blink phases),
//   BREATHE (level ramps 0..duty..0 one step per frame).
//
// Ports
//   mclk        clock, rising edge
//   mrst_n      asynchronous active-low reset
//   cfg_we      config write strobe (one channel per cycle)
//   cfg_ch      channel index for the write; indices >= NCH are ignored
//   cfg_mode    0 OFF, 1 ON, 2 BLINK, 3 BREATHE
//   cfg_duty    duty (ON/BLINK) or breathe peak (BREATHE)
//   prescale    tick divider, sampled every cycle (0 = tick every cycle)
//   led         registered LED drive, one bit per channel
//   frame_tick  registered one-cycle pulse following each PWM frame wrap
// -----------------------------------------------------------------------------
module led_pwm_ctrl #(
   parameter int NCH = 3,
   parameter int DW  = 8,
   parameter int PSW = 16,
   parameter int BLW = 6
) (
   input  logic           mclk,
   input  logic           mrst_n,
   input  logic           cfg_we,
   input  logic [3:0]     cfg_ch,
   input  logic [1:0]     cfg_mode,
   input  logic [DW-1:0]  cfg_duty,
   input  logic [PSW-1:0] prescale,
   output logic [NCH-1:0] led,
   output logic           frame_tick
);

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_ON      = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   // Shared timebase
   logic [PSW-1:0] psc_q, psc_d;
   logic [DW-1:0]  pwm_q, pwm_d;
   logic [BLW-1:0] blc_q, blc_d;
   logic           tick;
   logic           frame_evt;
   logic           frame_tick_q;
   logic [NCH-1:0] led_q, led_d;

   // Per-channel state
   logic [1:0]     sh_mode_q  [NCH];
   logic [1:0]     sh_mode_d  [NCH];
   logic [DW-1:0]  sh_duty_q  [NCH];
   logic [DW-1:0]  sh_duty_d  [NCH];
   logic [1:0]     act_mode_q [NCH];
   logic [1:0]     act_mode_d [NCH];
   logic [DW-1:0]  act_duty_q [NCH];
   logic [DW-1:0]  act_duty_d [NCH];
   logic [DW-1:0]  lvl_q      [NCH];
   logic [DW-1:0]  lvl_d      [NCH];
   logic           dir_dn_q   [NCH];
   logic           dir_dn_d   [NCH];
   logic [DW-1:0]  eff        [NCH];

   // Using >= rather than == means a prescale lowered below the running count
   // still ticks on the next cycle instead of waiting for a counter wrap.
   always_comb begin
      tick      = (psc_q >= prescale);
      psc_d     = tick ? '0 : psc_q + 1'b1;
      pwm_d     = tick ? pwm_q + 1'b1 : pwm_q;
      frame_evt = tick && (pwm_q == '1);
      blc_d     = frame_evt ? blc_q + 1'b1 : blc_q;
   end

   always_comb begin
      for (int ch = 0; ch < NCH; ch++) begin
         sh_mode_d[ch]  = sh_mode_q[ch];
         sh_duty_d[ch]  = sh_duty_q[ch];
         act_mode_d[ch] = act_mode_q[ch];
         act_duty_d[ch] = act_duty_q[ch];
         lvl_d[ch]      = lvl_q[ch];
         dir_dn_d[ch]   = dir_dn_q[ch];
         eff[ch]        = '0;
         led_d[ch]      = 1'b0;

         if (cfg_we && (cfg_ch == 4'(ch))) begin
            sh_mode_d[ch] = cfg_mode;
            sh_duty_d[ch] = cfg_duty;
         end

         // Commit reads the registered shadow, so a write landing on the same
         // cycle as the frame event is deferred to the following frame.
         if (frame_evt) begin
            act_mode_d[ch] = sh_mode_q[ch];
            act_duty_d[ch] = sh_duty_q[ch];
            if ((sh_mode_q[ch] == MODE_BREATHE) && (act_mode_q[ch] != MODE_BREATHE)) begin
               lvl_d[ch]    = '0;
               dir_dn_d[ch] = 1'b0;
            end else if (act_mode_q[ch] == MODE_BREATHE) begin
               if (!dir_dn_q[ch]) begin
                  if (lvl_q[ch] < act_duty_q[ch]) begin
                     lvl_d[ch] = lvl_q[ch] + 1'b1;
                  end else begin
                     dir_dn_d[ch] = 1'b1;
                     if (lvl_q[ch] != '0) lvl_d[ch] = lvl_q[ch] - 1'b1;
                  end
               end else begin
                  if (lvl_q[ch] != '0) begin
                     lvl_d[ch] = lvl_q[ch] - 1'b1;
                  end else begin
                     dir_dn_d[ch] = 1'b0;
                     if (act_duty_q[ch] != '0) lvl_d[ch] = DW'(1);
                  end
               end
            end
         end

         case (act_mode_q[ch])
            MODE_OFF:     eff[ch] = '0;
            MODE_ON:      eff[ch] = act_duty_q[ch];
            MODE_BLINK:   eff[ch] = blc_q[BLW-1] ? act_duty_q[ch] : '0;
            MODE_BREATHE: eff[ch] = lvl_q[ch];
            default:      eff[ch] = '0;
         endcase

         led_d[ch] = (pwm_q < eff[ch]);
      end
   end

   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         psc_q        <= '0;
         pwm_q        <= '0;
         blc_q        <= '0;
         frame_tick_q <= 1'b0;
         led_q        <= '0;
         for (int ch = 0; ch < NCH; ch++) begin
            sh_mode_q[ch]  <= MODE_OFF;
            sh_duty_q[ch]  <= '0;
            act_mode_q[ch] <= MODE_OFF;
            act_duty_q[ch] <= '0;
            lvl_q[ch]      <= '0;
            dir_dn_q[ch]   <= 1'b0;
         end
      end else begin
         psc_q        <= psc_d;
         pwm_q        <= pwm_d;
         blc_q        <= blc_d;
         frame_tick_q <= frame_evt;
         led_q        <= led_d;
         for (int ch = 0; ch < NCH; ch++) begin
            sh_mode_q[ch]  <= sh_mode_d[ch];
            sh_duty_q[ch]  <= sh_duty_d[ch];
            act_mode_q[ch] <= act_mode_d[ch];
            act_duty_q[ch] <= act_duty_d[ch];
            lvl_q[ch]      <= lvl_d[ch];
            dir_dn_q[ch]   <= dir_dn_d[ch];
         end
      end
   end

   assign led        = led_q;
   assign frame_tick = frame_tick_q;

endmodule
